serial_cmd_engine: RTL and testbench

//  Byte-stream command processor sitting between the RX and TX byte streams of serial_interface.

---
 rtl/serial_cmd_pkg.sv | 21 ++
 rtl/serial_cmd_if.sv | 21 ++
 rtl/serial_cmd_ram.sv | 27 ++
 rtl/serial_cmd_engine.sv | 164 ++++++++++++++++
 tb/tb_serial_cmd_engine.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmd_pkg.sv
// Shared opcodes, response codes and FSM state type for the serial command engine.
package serial_cmd_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] OP_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] RSP_ACK  = 8'h4B;
    localparam logic [BYTE_W-1:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        WDATA,
        WACK,
        RDATA,
        ERR
    } cmd_state_t;

endpackage

// File: rtl/serial_cmd_if.sv
// RX/TX byte-stream pair between serial_interface (master) and the command engine (slave).
interface serial_cmd_if;
    import serial_cmd_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/serial_cmd_ram.sv
// Byte RAM with one synchronous write port and one asynchronous read port; contents not reset.
module serial_cmd_ram
    import serial_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_cmd_engine.sv
// Byte-stream command processor: 'W' addr len data.. -> 'K', 'R' addr len -> data.., else '?'.
module serial_cmd_engine
    import serial_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic         clk,
    input  logic         nrst,
    serial_cmd_if.slave  bus
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    cmd_state_t          state_q, state_d;
    logic                op_read_q, op_read_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BYTE_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;

    logic                rx_ready_c;
    logic                rx_fire_c;
    logic                tx_fire_c;
    logic                we_c;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic [BYTE_W-1:0]   rd_data_c;
    logic                timed_state_c;

    // Accept bytes only in the receive states; held low while in reset.
    assign rx_ready_c = nrst && (state_q == IDLE || state_q == ADDR ||
                                 state_q == LEN  || state_q == WDATA);
    assign rx_fire_c  = bus.rx_valid && rx_ready_c;
    assign tx_fire_c  = tx_valid_q && bus.tx_ready;
    assign timed_state_c = (state_q == ADDR) || (state_q == LEN) || (state_q == WDATA);

    // RDATA prefetches the next byte so consecutive reads stream without a bubble.
    assign rd_addr_c = (state_q == RDATA) ? (ptr_q + ADDR_W'(1)) : ptr_q;

    assign bus.rx_ready = rx_ready_c;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

    serial_cmd_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (ptr_q),
        .wdata_i (bus.rx_data),
        .raddr_i (rd_addr_c),
        .rdata_o (rd_data_c)
    );

    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        timer_d    = '0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        we_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_fire_c) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        op_read_d = (bus.rx_data == OP_READ);
                        state_d   = ADDR;
                    end else begin
                        tx_data_d  = RSP_ERR;
                        tx_valid_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end
            ADDR: begin
                if (rx_fire_c) begin
                    ptr_d   = ADDR_W'(bus.rx_data);
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_fire_c) begin
                    cnt_d = bus.rx_data;
                    if (op_read_q) begin
                        tx_data_d  = rd_data_c;
                        tx_valid_d = 1'b1;
                        state_d    = RDATA;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (rx_fire_c) begin
                    we_c  = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - BYTE_W'(1);
                    if (cnt_q == '0) begin
                        tx_data_d  = RSP_ACK;
                        tx_valid_d = 1'b1;
                        state_d    = WACK;
                    end
                end
            end
            WACK, ERR: begin
                if (tx_fire_c) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RDATA: begin
                if (tx_fire_c) begin
                    if (cnt_q == '0) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        ptr_d     = ptr_q + ADDR_W'(1);
                        cnt_d     = cnt_q - BYTE_W'(1);
                        tx_data_d = rd_data_c;
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        // Abandon a stalled command; bytes already written stay in RAM.
        if (timed_state_c && !rx_fire_c) begin
            if (timer_q == TIMER_LAST) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            op_read_q  <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_read_q  <= op_read_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Randomized bench for serial_cmd_engine against a byte-array protocol model.
module tb_serial_cmd_engine;

    localparam int unsigned TO = 16;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    serial_cmd_if bus();

    serial_cmd_engine #(
        .ADDR_W      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    logic [7:0]  ref_mem [256];
    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  wdata_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned last_rx_cyc = 0;
    int          tx_mode = 0;
    logic        pend    = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // tx_ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                2:       bus.tx_ready = 1'($urandom_range(0, 1));
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: records accepted bytes, checks hold-until-accepted and rx/tx exclusivity.
    initial forever begin
        @(negedge clk);
        if (nrst) begin
            if (pend) begin
                check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
                check("tx_hold_data", 32'(bus.tx_data), 32'(pend_data));
            end
            check("rx_ready_vs_tx_valid", 32'(bus.rx_ready), 32'(!bus.tx_valid));
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(bus.tx_data);
                got_t.push_back(cyc + 1);
            end
            pend      = bus.tx_valid && !bus.tx_ready;
            pend_data = bus.tx_data;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.rx_ready) break;
        end
        if (k == 500) check("rx_accept_timeout", 32'd0, 32'd1);
        step();
        last_rx_cyc  = cyc;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        for (k = 0; k < 4000 && got_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        step();
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    // Reference: the response is a pure function of the command bytes and the byte-array model.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] len,
                          input string tag, input bit gaps);
        logic [7:0] cmd[$];
        int unsigned n;
        n = int'(len) + 1;
        exp_q.delete();
        got_q.delete();
        got_t.delete();
        cmd.push_back(op);
        if (op == 8'h57 || op == 8'h52) begin
            cmd.push_back(addr);
            cmd.push_back(len);
        end
        if (op == 8'h57) begin
            for (int i = 0; i < n; i++) begin
                cmd.push_back(wdata_q[i]);
                ref_mem[(int'(addr) + i) % 256] = wdata_q[i];
            end
            exp_q.push_back(8'h4B);
        end else if (op == 8'h52) begin
            for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(addr) + i) % 256]);
        end else begin
            exp_q.push_back(8'h3F);
        end
        for (int i = 0; i < cmd.size(); i++) begin
            send_byte(cmd[i]);
            if (gaps) repeat ($urandom_range(0, 2)) step();
        end
        wait_rsp(tag);
    endtask

    task automatic set_wdata_rand(input int unsigned n);
        wdata_q.delete();
        for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2 nrst = 1'b0;
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;
        step();
        check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
        tx_mode = 0;

        // Full 256-byte write then readback: len=0xFF boundary and defined RAM contents.
        set_wdata_rand(256);
        do_cmd(8'h57, 8'h00, 8'hFF, "fill_write", 1'b0);
        do_cmd(8'h52, 8'h00, 8'hFF, "fill_read", 1'b0);

        // Test 1: write/read with latency and back-to-back streaming.
        wdata_q.delete();
        wdata_q.push_back(8'hAA); wdata_q.push_back(8'hBB); wdata_q.push_back(8'hCC);
        do_cmd(8'h57, 8'h10, 8'h02, "t1_write", 1'b0);
        check("t1_ack_latency", (got_t.size() > 0) ? got_t[0] : 32'd0, last_rx_cyc + 1);
        do_cmd(8'h52, 8'h10, 8'h02, "t1_read", 1'b0);
        check("t1_read_latency", (got_t.size() > 0) ? got_t[0] : 32'd0, last_rx_cyc + 1);
        for (int i = 1; i < 3; i++)
            check($sformatf("t1_b2b[%0d]", i), (got_t.size() > i) ? got_t[i] : 32'd0,
                  last_rx_cyc + 1 + i);

        // Test 2: address wrap.
        wdata_q.delete();
        wdata_q.push_back(8'h11); wdata_q.push_back(8'h22); wdata_q.push_back(8'h33);
        do_cmd(8'h57, 8'hFE, 8'h02, "t2_write", 1'b0);
        do_cmd(8'h52, 8'hFE, 8'h02, "t2_read", 1'b0);
        do_cmd(8'h52, 8'h00, 8'h00, "t2_read0", 1'b0);

        // Test 3: bad opcode then recovery.
        do_cmd(8'h41, 8'h00, 8'h00, "t3_bad", 1'b0);
        do_cmd(8'h52, 8'h10, 8'h00, "t3_recover", 1'b0);

        // Test 4: backpressure on a 4-byte read.
        tx_mode = 1;
        do_cmd(8'h52, 8'h10, 8'h03, "t4_bp_read", 1'b0);
        tx_mode = 0;

        // Test 5: timeout mid-command, and a partial write that must persist.
        got_q.delete();
        send_byte(8'h57);
        send_byte(8'h20);
        repeat (TO + 4) step();
        check("t5_no_tx", 32'(got_q.size()), 32'd0);
        do_cmd(8'h52, 8'h20, 8'h00, "t5_old_data", 1'b0);
        got_q.delete();
        send_byte(8'h57);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h77);
        ref_mem[8'h30] = 8'h77;
        repeat (TO + 4) step();
        check("t5_partial_no_tx", 32'(got_q.size()), 32'd0);
        do_cmd(8'h52, 8'h30, 8'h01, "t5_partial_read", 1'b0);

        // Test 6: asynchronous reset while a read response is pending.
        tx_mode = 3;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h03);
        @(negedge clk);
        check("t6_pending_valid", 32'(bus.tx_valid), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("t6_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("t6_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        step();
        tx_mode = 0;
        got_q.delete();
        wdata_q.delete();
        wdata_q.push_back(8'h5A);
        do_cmd(8'h57, 8'h00, 8'h00, "t6_after_rst", 1'b0);
        do_cmd(8'h52, 8'h00, 8'h00, "t6_readback", 1'b0);

        // Random command mix with random backpressure and inter-byte gaps.
        tx_mode = 2;
        for (int c = 0; c < 40; c++) begin
            int unsigned r;
            logic [7:0] op, a, l;
            r = $urandom_range(0, 9);
            a = 8'($urandom);
            l = (c == 20) ? 8'hFF : 8'($urandom_range(0, 7));
            if (r < 4)      op = 8'h57;
            else if (r < 8) op = 8'h52;
            else begin
                op = 8'($urandom);
                if (op == 8'h57 || op == 8'h52) op = 8'h41;
            end
            set_wdata_rand(int'(l) + 1);
            do_cmd(op, a, l, $sformatf("rnd%0d", c), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
